bus_hold_arbiter: RTL and testbench

Arbitrates the shared system address/data bus between the processor (default owner) and up to `N_REQ` external bus masters (DMA channels, PCI-side masters). Requests are collected, the processor is asked to release the bus via the HRQ/HLDA hold handshake, and one master at a time receives a one-hot grant under round-robin priority with a bounded tenure. The `aen` output is the bus-ownership code; the processor drives address/data only while `aen == 2'b00`.

---
 rtl/bus_hold_arbiter_if.sv | 26 ++
 rtl/bus_hold_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_hold_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_hold_arbiter_if.sv
// Bus-hold arbitration bundle: level requests and processor hold handshake in,
// one-hot grant, hold request and ownership code out.
interface bus_hold_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic             hlda;
  logic             hrq;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       aen;
  logic [IW-1:0]    owner_id;
  logic             busy;

  // slave = arbiter side, master = requesters plus processor side
  modport slave (
    input  req, hlda,
    output hrq, gnt, aen, owner_id, busy
  );

  modport master (
    output req, hlda,
    input  hrq, gnt, aen, owner_id, busy
  );
endinterface

// File: rtl/bus_hold_arbiter.sv
// Round-robin bus arbiter with HRQ/HLDA hold handshake and bounded tenure; all outputs registered.
// Request-to-grant is 3 edges minimum; hlda low aborts any tenure and returns the bus to the processor.
module bus_hold_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_TENURE = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  bus_hold_arbiter_if.slave   bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(MAX_TENURE + 1);

  localparam logic [IW:0]   NQ       = (IW + 1)'(N_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);
  localparam logic [TW-1:0] TEN_SAT  = '1;

  localparam logic [1:0] AEN_CPU  = 2'b00;
  localparam logic [1:0] AEN_IDLE = 2'b01;
  localparam logic [1:0] AEN_MST  = 2'b10;

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    HOLD_REQ = 3'd1,
    TURN     = 3'd2,
    GRANT    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [TW-1:0]    tenure;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [IW:0]      best_dist;
  logic [IW:0]      cand_dist;
  logic [IW-1:0]    cand;
  logic [IW-1:0]    owner_nxt;
  logic             tenure_end;

  // Winner = requester with the smallest distance above the pointer, modulo N_REQ.
  always_comb begin
    win_vld    = 1'b0;
    win_idx    = '0;
    best_dist  = '0;
    cand       = '0;
    cand_dist  = '0;
    win_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand      = IW'(j);
      cand_dist = {1'b0, cand} - {1'b0, ptr};
      if (cand < ptr) begin
        cand_dist = cand_dist + NQ;
      end
      if (bus.req[j] && (!win_vld || (cand_dist < best_dist))) begin
        win_vld   = 1'b1;
        win_idx   = cand;
        best_dist = cand_dist;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  assign owner_nxt  = (bus.owner_id == LAST_IDX) ? '0 : bus.owner_id + IW'(1);
  assign tenure_end = !bus.req[bus.owner_id] || (tenure == TEN_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CPU_OWN;
      bus.hrq      <= 1'b0;
      bus.gnt      <= '0;
      bus.aen      <= AEN_CPU;
      bus.owner_id <= '0;
      bus.busy     <= 1'b0;
      ptr          <= '0;
      tenure       <= '0;
    end else begin
      case (state)
        CPU_OWN: begin
          if (|bus.req) begin
            state    <= HOLD_REQ;
            bus.hrq  <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        HOLD_REQ: begin
          if (bus.hlda) begin
            state   <= TURN;
            bus.aen <= AEN_IDLE;
          end else if (!(|bus.req)) begin
            state    <= CPU_OWN;
            bus.hrq  <= 1'b0;
            bus.busy <= 1'b0;
          end
        end
        TURN: begin
          if (!bus.hlda || !win_vld) begin
            state   <= RELEASE;
            bus.hrq <= 1'b0;
          end else begin
            state        <= GRANT;
            bus.gnt      <= win_onehot;
            bus.aen      <= AEN_MST;
            bus.owner_id <= win_idx;
            tenure       <= '0;
          end
        end
        GRANT: begin
          // An expired or aborted owner drops to lowest priority.
          if (!bus.hlda || tenure_end) begin
            bus.gnt <= '0;
            bus.aen <= AEN_IDLE;
            ptr     <= owner_nxt;
            if (!bus.hlda) begin
              state   <= RELEASE;
              bus.hrq <= 1'b0;
            end else begin
              state <= TURN;
            end
          end else if (tenure != TEN_SAT) begin
            tenure <= tenure + TW'(1);
          end
        end
        RELEASE: begin
          if (!bus.hlda) begin
            state    <= CPU_OWN;
            bus.aen  <= AEN_CPU;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state <= CPU_OWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Randomized bench for bus_hold_arbiter against a bus-ownership reference model.
module tb_bus_hold_arbiter;

  localparam int N   = 4;
  localparam int MAX = 5;

  localparam int P_CPU = 0;
  localparam int P_ASK = 1;
  localparam int P_GAP = 2;
  localparam int P_TEN = 3;
  localparam int P_RET = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  bus_hold_arbiter_if #(.N_REQ(N)) bus ();

  bus_hold_arbiter #(.N_REQ(N), .MAX_TENURE(MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, how long the current owner has had it.
  int m_phase, m_aen, m_owner, m_used, m_ptr;
  bit m_hrq;

  int abort_cnt = 0;
  bit cpu_stuck = 1'b0;
  int lag_pct   = 0;
  bit ok;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_CPU;
    m_hrq   = 1'b0;
    m_aen   = 0;
    m_owner = -1;
    m_used  = 0;
    m_ptr   = 0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic h);
    case (m_phase)
      P_CPU: if (r != 0) begin m_phase = P_ASK; m_hrq = 1'b1; end
      P_ASK: begin
        if (h) begin m_phase = P_GAP; m_aen = 1; end
        else if (r == 0) begin m_phase = P_CPU; m_hrq = 1'b0; end
      end
      P_GAP: begin
        if (h && r != 0) begin
          m_owner = rr_pick(r, m_ptr);
          m_used  = 1;
          m_aen   = 2;
          m_phase = P_TEN;
        end else begin
          m_hrq   = 1'b0;
          m_phase = P_RET;
        end
      end
      P_TEN: begin
        if (!h || !r[m_owner] || m_used == MAX) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_aen   = 1;
          if (!h) begin m_hrq = 1'b0; m_phase = P_RET; end
          else m_phase = P_GAP;
        end else begin
          m_used++;
        end
      end
      P_RET: if (!h) begin m_aen = 0; m_phase = P_CPU; end
      default: m_phase = P_CPU;
    endcase
  endtask

  task automatic compare();
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_eq("hrq", 32'(bus.hrq), 32'(m_hrq));
    check_eq("aen", 32'(bus.aen), m_aen);
    check_eq("gnt", 32'(bus.gnt), exp_gnt);
    check_eq("busy", 32'(bus.busy), 32'(m_phase != P_CPU));
    if (m_aen == 2) check_eq("owner_id", 32'(bus.owner_id), m_owner);
    check_eq("gnt_with_cpu_aen", 32'((bus.gnt != 0) && (bus.aen == 2'b00)), 0);
  endtask

  task automatic drive_hlda();
    if (abort_cnt > 0) begin
      bus.hlda = 1'b0;
      abort_cnt--;
    end else if (cpu_stuck) begin
      bus.hlda = 1'b0;
    end else if ($urandom_range(0, 99) >= lag_pct) begin
      bus.hlda = bus.hrq;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(bus.req, bus.hlda);
    #1;
    compare();
    drive_hlda();
  endtask

  task automatic wait_gnt(input logic [N-1:0] target, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      if (bus.gnt == target) hit = 1'b1;
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.hlda = 1'b0;
    model_reset();

    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_hrq", 32'(bus.hrq), 0);
    check_eq("rst_gnt", 32'(bus.gnt), 0);
    check_eq("rst_aen", 32'(bus.aen), 0);
    check_eq("rst_owner", 32'(bus.owner_id), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Single requester held for a few cycles.
    bus.req = 4'b0001;
    for (int i = 0; i < 7; i++) cycle();
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) cycle();

    // All requesting: tenures rotate through every master.
    bus.req = 4'b1111;
    for (int i = 0; i < 40; i++) cycle();
    bus.req = 4'b0000;
    for (int i = 0; i < 10; i++) cycle();

    // Withdrawal before the processor answers.
    cpu_stuck = 1'b1;
    bus.hlda  = 1'b0;
    bus.req   = 4'b0100;
    cycle();
    bus.req = 4'b0000;
    for (int i = 0; i < 5; i++) cycle();
    cpu_stuck = 1'b0;

    // Abort during the third grant cycle of master 2.
    bus.req = 4'b1100;
    wait_gnt(4'b0100, 40, ok);
    check_eq("abort_wait_m2", 32'(ok), 1);
    cycle();
    bus.hlda  = 1'b0;
    abort_cnt = 3;
    cycle();
    check_eq("abort_gnt", 32'(bus.gnt), 0);
    check_eq("abort_aen", 32'(bus.aen), 1);
    check_eq("abort_hrq", 32'(bus.hrq), 0);
    wait_gnt(4'b1000, 40, ok);
    check_eq("abort_next_m3", 32'(ok), 1);
    bus.req = 4'b0000;
    for (int i = 0; i < 10; i++) cycle();

    // Randomized traffic with a lagging, occasionally aborting processor.
    lag_pct = 25;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 99) < 15) bus.req[b] = ~bus.req[b];
      end
      if (bus.hlda && $urandom_range(0, 99) < 3) begin
        bus.hlda  = 1'b0;
        abort_cnt = $urandom_range(0, 2);
      end
      cycle();
    end
    lag_pct   = 0;
    abort_cnt = 0;
    bus.req   = 4'b0000;
    for (int i = 0; i < 12; i++) cycle();

    // Asynchronous reset in the middle of a grant.
    bus.req = 4'b0001;
    wait_gnt(4'b0001, 20, ok);
    check_eq("areset_wait_grant", 32'(ok), 1);
    cycle();
    #3 reset_n = 1'b0;
    #1;
    check_eq("areset_gnt", 32'(bus.gnt), 0);
    check_eq("areset_hrq", 32'(bus.hrq), 0);
    check_eq("areset_aen", 32'(bus.aen), 0);
    check_eq("areset_busy", 32'(bus.busy), 0);
    model_reset();
    bus.hlda = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    wait_gnt(4'b0001, 10, ok);
    check_eq("areset_regrant_m0", 32'(ok), 1);
    bus.req = 4'b0000;
    for (int i = 0; i < 10; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
